// File: rtl/adc_frame_gate_if.sv
// ---------------------------------------------------------------------------
// adc_frame_gate_if
// Bundles the ADC-side input stream and the frame-gated output stream of
// adc_frame_gate.
//   master : the ADC/control side. Drives enable_sw, buff_full, data and
//            data_valid. Observes the gated stream, status and counters.
//   slave  : adc_frame_gate itself. Consumes the inputs and drives
//            sample_out, sample_valid, frame_start, frame_last, busy,
//            frames_done, drop_cnt and overrun.
// ---------------------------------------------------------------------------
interface adc_frame_gate_if;

    logic        enable_sw;
    logic        buff_full;
    logic [11:0] data;
    logic        data_valid;

    logic [15:0] sample_out;
    logic        sample_valid;
    logic        frame_start;
    logic        frame_last;
    logic        busy;
    logic [15:0] frames_done;
    logic [15:0] drop_cnt;
    logic        overrun;

    modport master (
        output enable_sw,
        output buff_full,
        output data,
        output data_valid,
        input  sample_out,
        input  sample_valid,
        input  frame_start,
        input  frame_last,
        input  busy,
        input  frames_done,
        input  drop_cnt,
        input  overrun
    );

    modport slave (
        input  enable_sw,
        input  buff_full,
        input  data,
        input  data_valid,
        output sample_out,
        output sample_valid,
        output frame_start,
        output frame_last,
        output busy,
        output frames_done,
        output drop_cnt,
        output overrun
    );

endinterface

// File: rtl/adc_frame_gate.sv
// ---------------------------------------------------------------------------
// adc_frame_gate
// Sign-extends the 12-bit ADC stream, optionally decimates it by block
// averaging (DECIM = 1, 2, 4, 8 or 16), and forwards only whole frames of
// FRAME_LEN samples to the FFT. Frames never start or stop part-way through;
// samples that arrive while the output buffer is full during a frame are
// counted as drops.
//
// Parameters
//   FRAME_LEN : samples per frame, power of two, 2..65536
//   DECIM     : decimation factor, 1/2/4/8/16
// Ports
//   CLK       : system clock
//   rst       : asynchronous, active-high reset
//   bus       : adc_frame_gate_if.slave
//               in : enable_sw, buff_full, data[11:0], data_valid
//               out: sample_out[15:0], sample_valid, frame_start,
//                    frame_last, busy, frames_done[15:0], drop_cnt[15:0],
//                    overrun (all registered)
// ---------------------------------------------------------------------------
module adc_frame_gate #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned DECIM     = 1
) (
    input  logic              CLK,
    input  logic              rst,
    adc_frame_gate_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned SHIFT = $clog2(DECIM);
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_t                state_q,       state_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic signed [15:0]    acc_q,         acc_d;
    logic [PH_W-1:0]       phase_q,       phase_d;
    logic [15:0]           sample_out_q,  sample_out_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_last_q,  frame_last_d;
    logic                  busy_q,        busy_d;
    logic [15:0]           frames_done_q, frames_done_d;
    logic [15:0]           drop_cnt_q,    drop_cnt_d;
    logic                  overrun_q,     overrun_d;

    // Decimator combinational results
    logic signed [15:0]    x_ext_c;
    logic signed [15:0]    sum_c;
    logic signed [15:0]    dec_sample_c;
    logic                  dec_valid_c;

    // Frame-gate helper
    logic                  fwd_c;

    // -----------------------------------------------------------------------
    // Decimator: free-running block averager, independent of the FSM state.
    // The block sum of up to 16 sign-extended 12-bit samples fits 16 bits.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d        = acc_q;
        phase_d      = phase_q;
        x_ext_c      = {{4{bus.data[11]}}, bus.data};
        sum_c        = acc_q + x_ext_c;
        dec_valid_c  = bus.data_valid && (phase_q == PH_LAST);
        // Arithmetic shift: floor of the block mean.
        dec_sample_c = sum_c >>> SHIFT;

        if (bus.data_valid) begin
            if (phase_q == PH_LAST) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum_c;
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame gate: next state, sample index, output strobes and counters.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        frame_start_d  = 1'b0;
        frame_last_d   = 1'b0;
        frames_done_d  = frames_done_q;
        drop_cnt_d     = drop_cnt_q;
        overrun_d      = overrun_q;
        fwd_c          = 1'b0;

        case (state_q)
            IDLE: begin
                // A full buffer only defers the start; it is not a drop.
                if (dec_valid_c && bus.enable_sw && !bus.buff_full) begin
                    fwd_c   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // enable_sw is ignored here so that a frame always completes.
                if (dec_valid_c) begin
                    if (bus.buff_full) begin
                        overrun_d = 1'b1;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end else begin
                        fwd_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fwd_c) begin
            sample_valid_d = 1'b1;
            sample_out_d   = dec_sample_c;
            frame_start_d  = (idx_q == '0);
            if (idx_q == IDX_LAST) begin
                frame_last_d  = 1'b1;
                idx_d         = '0;
                frames_done_d = frames_done_q + 16'd1;
                // Continue straight into the next frame only while enabled.
                if (!bus.enable_sw) begin
                    state_d = IDLE;
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // busy stays high through the frame_last cycle, then follows the state.
        busy_d = (state_d == RUN) || frame_last_d;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            phase_q        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_last_q   <= 1'b0;
            busy_q         <= 1'b0;
            frames_done_q  <= '0;
            drop_cnt_q     <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            phase_q        <= phase_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            frame_start_q  <= frame_start_d;
            frame_last_q   <= frame_last_d;
            busy_q         <= busy_d;
            frames_done_q  <= frames_done_d;
            drop_cnt_q     <= drop_cnt_d;
            overrun_q      <= overrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.frame_last   = frame_last_q;
    assign bus.busy         = busy_q;
    assign bus.frames_done  = frames_done_q;
    assign bus.drop_cnt     = drop_cnt_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_frame_gate.sv
// ---------------------------------------------------------------------------
// tb_adc_frame_gate
// Two instances share one input stream: u1 (FRAME_LEN=8, DECIM=1) and
// u4 (FRAME_LEN=8, DECIM=4). Every cycle both are compared against a
// per-strobe reference model; directed tables and sequences add explicit
// expectations for the basic frame, decimation, enable drop, overrun,
// back-to-back frames and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_adc_frame_gate;

    localparam int FL = 8;

    logic CLK;
    logic rst;

    adc_frame_gate_if if1 ();
    adc_frame_gate_if if4 ();

    adc_frame_gate #(.FRAME_LEN(FL), .DECIM(1)) u1 (.CLK(CLK), .rst(rst), .bus(if1));
    adc_frame_gate #(.FRAME_LEN(FL), .DECIM(4)) u4 (.CLK(CLK), .rst(rst), .bus(if4));

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, advanced once per clock.
    typedef struct {
        int          sum;
        int          cnt;
        bit          active;
        int          pos;
        int          frames;
        int          drops;
        bit          ovr;
        logic [15:0] out;
        bit          v;
        bit          s;
        bit          l;
        bit          busy;
    } mdl_t;

    mdl_t m1, m4;

    typedef struct {
        bit          dv;
        logic [11:0] d;
        bit          en;
        bit          ev;
        logic [15:0] eo;
        bit          es;
        bit          el;
        bit          eb;
        logic [15:0] ef;
    } vec_t;

    vec_t tv[10];

    int vcnt, scnt, lcnt, low_cnt, follow_cnt;
    bit prev_last;
    bit en_r;

    function automatic mdl_t mreset();
        mdl_t m;
        m.sum = 0; m.cnt = 0; m.active = 0; m.pos = 0; m.frames = 0;
        m.drops = 0; m.ovr = 0; m.out = '0; m.v = 0; m.s = 0; m.l = 0;
        m.busy = 0;
        return m;
    endfunction

    // One clock of the model: mean of each DECIM-sample block (floored),
    // then whole-frame gating of those means.
    function automatic mdl_t mstep(input mdl_t mi, input int dec, input bit dv,
                                   input logic [11:0] d, input bit en, input bit bf);
        mdl_t m;
        int   x, q;
        bit   emit;
        m = mi;
        m.v = 0; m.s = 0; m.l = 0;
        emit = 0;
        if (dv) begin
            x = $signed(d);
            m.sum = m.sum + x;
            m.cnt = m.cnt + 1;
            if (m.cnt == dec) begin
                if (m.sum >= 0) q = m.sum / dec;
                else            q = -((-m.sum + dec - 1) / dec);
                m.sum = 0;
                m.cnt = 0;
                if (!m.active) begin
                    if (en && !bf) begin
                        m.active = 1;
                        m.pos    = 0;
                        emit     = 1;
                    end
                end else if (bf) begin
                    if (m.drops < 65535) m.drops = m.drops + 1;
                    m.ovr = 1;
                end else begin
                    emit = 1;
                end
                if (emit) begin
                    m.v   = 1;
                    m.out = 16'(q);
                    m.s   = (m.pos == 0);
                    m.pos = m.pos + 1;
                    if (m.pos == FL) begin
                        m.l      = 1;
                        m.pos    = 0;
                        m.frames = (m.frames + 1) % 65536;
                        if (!en) m.active = 0;
                    end
                end
            end
        end
        m.busy = m.active || m.l;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input mdl_t m, input logic [15:0] so,
                           input logic sv, input logic fs, input logic fl, input logic bz,
                           input logic [15:0] fd, input logic [15:0] dc, input logic ov);
        chk({tag, ".sample_out"},   32'(so), 32'(m.out));
        chk({tag, ".sample_valid"}, 32'(sv), 32'(m.v));
        chk({tag, ".frame_start"},  32'(fs), 32'(m.s));
        chk({tag, ".frame_last"},   32'(fl), 32'(m.l));
        chk({tag, ".busy"},         32'(bz), 32'(m.busy));
        chk({tag, ".frames_done"},  32'(fd), 32'(16'(m.frames)));
        chk({tag, ".drop_cnt"},     32'(dc), 32'(16'(m.drops)));
        chk({tag, ".overrun"},      32'(ov), 32'(m.ovr));
    endtask

    task automatic chk_both();
        chk_dut("u1", m1, if1.sample_out, if1.sample_valid, if1.frame_start, if1.frame_last,
                if1.busy, if1.frames_done, if1.drop_cnt, if1.overrun);
        chk_dut("u4", m4, if4.sample_out, if4.sample_valid, if4.frame_start, if4.frame_last,
                if4.busy, if4.frames_done, if4.drop_cnt, if4.overrun);
    endtask

    task automatic drive(input bit dv, input logic [11:0] d, input bit en, input bit bf);
        if1.data_valid = dv; if1.data = d; if1.enable_sw = en; if1.buff_full = bf;
        if4.data_valid = dv; if4.data = d; if4.enable_sw = en; if4.buff_full = bf;
    endtask

    // Entered and left at posedge+1: apply inputs, advance models, clock, compare.
    task automatic cycle(input bit dv, input logic [11:0] d, input bit en, input bit bf);
        drive(dv, d, en, bf);
        m1 = mstep(m1, 1, dv, d, en, bf);
        m4 = mstep(m4, 4, dv, d, en, bf);
        @(posedge CLK);
        #1;
        chk_both();
        if (if1.sample_valid) vcnt++;
        if (if1.frame_start)  scnt++;
        if (if1.frame_last)   lcnt++;
    endtask

    // Async reset: outputs must be zero before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        drive(0, 12'h000, 0, 0);
        #1;
        m1 = mreset();
        m4 = mreset();
        chk_both();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk_both();
        rst = 1'b0;
        vcnt = 0; scnt = 0; lcnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, elapsed %0t, limit 1ms", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 12'h000, 0, 0);
        m1 = mreset();
        m4 = mreset();

        // Basic frame on u1: data 0..7, enable dropped with the last strobe.
        tv[0] = '{1, 12'h000, 1, 1, 16'h0000, 1, 0, 1, 16'd0};
        for (int i = 1; i < 7; i++)
            tv[i] = '{1, 12'(i), 1, 1, 16'(i), 0, 0, 1, 16'd0};
        tv[7] = '{1, 12'h007, 0, 1, 16'h0007, 0, 1, 1, 16'd1};
        tv[8] = '{0, 12'h000, 0, 0, 16'h0007, 0, 0, 0, 16'd1};
        tv[9] = '{1, 12'h005, 0, 0, 16'h0007, 0, 0, 0, 16'd1};

        @(posedge CLK);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cycle(tv[i].dv, tv[i].d, tv[i].en, 0);
            chk($sformatf("tbl%0d.valid", i), 32'(if1.sample_valid), 32'(tv[i].ev));
            chk($sformatf("tbl%0d.out", i),   32'(if1.sample_out),   32'(tv[i].eo));
            chk($sformatf("tbl%0d.start", i), 32'(if1.frame_start),  32'(tv[i].es));
            chk($sformatf("tbl%0d.last", i),  32'(if1.frame_last),   32'(tv[i].el));
            chk($sformatf("tbl%0d.busy", i),  32'(if1.busy),         32'(tv[i].eb));
            chk($sformatf("tbl%0d.frames", i), 32'(if1.frames_done), 32'(tv[i].ef));
        end

        // Sign extension and decimation by 4 on u4.
        do_reset();
        cycle(1, 12'h800, 1, 0);
        cycle(1, 12'h800, 1, 0);
        cycle(1, 12'h7FF, 1, 0);
        chk("dec.no_early_valid", 32'(if4.sample_valid), 32'd0);
        cycle(1, 12'h7FF, 1, 0);
        chk("dec.valid", 32'(if4.sample_valid), 32'd1);
        chk("dec.neg_mean", 32'(if4.sample_out), 32'h0000FFFF);
        chk("dec.start", 32'(if4.frame_start), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1, 12'h7FF, 1, 0);
        chk("dec.pos_mean", 32'(if4.sample_out), 32'h000007FF);
        cycle(0, 12'h000, 1, 0);
        chk("dec.hold_out", 32'(if4.sample_out), 32'h000007FF);
        chk("dec.pulse_width", 32'(if4.sample_valid), 32'd0);

        // enable_sw dropped after the 3rd sample: frame still completes.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 12'(16 + i), 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 12'(32 + i), 0, 0);
        chk("endrop.last", 32'(if1.frame_last), 32'd1);
        chk("endrop.count", 32'(vcnt), 32'd8);
        cycle(0, 12'h000, 0, 0);
        chk("endrop.idle", 32'(if1.busy), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) cycle(1, 12'(i), 0, 0);
        chk("endrop.no_more", 32'(vcnt), 32'd0);

        // Overrun: two strobes dropped mid-frame, then buff_full in IDLE.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 12'(i), 1, 0);
        cycle(1, 12'h0AA, 1, 1);
        cycle(1, 12'h0BB, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 12'(3 + i), 0, 0);
        chk("ovr.last", 32'(if1.frame_last), 32'd1);
        chk("ovr.last_value", 32'(if1.sample_out), 32'h00000007);
        chk("ovr.total", 32'(vcnt), 32'd8);
        cycle(0, 12'h000, 0, 0);
        chk("ovr.drop_cnt", 32'(if1.drop_cnt), 32'd2);
        chk("ovr.sticky", 32'(if1.overrun), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 4; i++) cycle(1, 12'(i), 1, 1);
        chk("ovr.idle_no_start", 32'(vcnt), 32'd0);
        chk("ovr.idle_no_drop", 32'(if1.drop_cnt), 32'd2);
        chk("ovr.idle_busy", 32'(if1.busy), 32'd0);

        // Back-to-back frames with enable held high.
        do_reset();
        low_cnt = 0; follow_cnt = 0; prev_last = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1, 12'(i * 37), 1, 0);
            if (!if1.busy) low_cnt++;
            if (if1.frame_start && prev_last) follow_cnt++;
            prev_last = if1.frame_last;
        end
        chk("b2b.valid", 32'(vcnt), 32'd24);
        chk("b2b.starts", 32'(scnt), 32'd3);
        chk("b2b.lasts", 32'(lcnt), 32'd3);
        chk("b2b.start_follows_last", 32'(follow_cnt), 32'd2);
        chk("b2b.frames_done", 32'(if1.frames_done), 32'd3);
        chk("b2b.busy_low_cycles", 32'(low_cnt), 32'd0);

        // Asynchronous reset after sample 5, then a clean restart.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 12'(100 + i), 1, 0);
        chk("rstmid.pre_value", 32'(if1.sample_out), 32'd104);
        #4;
        do_reset();
        cycle(1, 12'h0AB, 1, 0);
        chk("rstmid.start", 32'(if1.frame_start), 32'd1);
        chk("rstmid.frames", 32'(if1.frames_done), 32'd0);
        chk("rstmid.value", 32'(if1.sample_out), 32'h000000AB);

        // Randomized traffic against the model.
        do_reset();
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) en_r = ~en_r;
            cycle(($urandom_range(0, 3) != 0), 12'($urandom), en_r,
                  ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
